md_stall_ctrl: RTL

//   Scheduler for the multiply/divide (HI/LO) unit and write-enable source for the pipeline registers.

---
 rtl/md_stall_ctrl_pkg.sv | 19 +
 rtl/md_busy_counter.sv | 66 ++++++
 rtl/md_stall_ctrl.sv | 64 ++++++
 3 files changed

// File: rtl/md_stall_ctrl_pkg.sv
// Shared constants and types for the multiply/divide scheduler and pipeline stall control.
package md_stall_ctrl_pkg;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;
  localparam int unsigned MD_CNT_W_DEF       = 4;
  localparam int unsigned STALL_CNT_W        = 32;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Performance counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// HI/LO occupancy tracker: IDLE/BUSY FSM with a down-counter, busy flag and commit pulse.
module md_busy_counter
  import md_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = MD_CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o,
  output logic done_o
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             done_q,  done_d;

  // NOTE: every variable gets its default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      MD_BUSY: begin
        // A second start while busy is deliberately ignored: no reload, no restart.
        if (cnt_q == CNT_W'(1)) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q == MD_BUSY);
  assign done_o = done_q;

endmodule

// File: rtl/md_stall_ctrl.sv
// HI/LO scheduler top: merges the HI/LO stall with the data-hazard stall into pipeline register controls.
module md_stall_ctrl
  import md_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = MD_CNT_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   e_start_i,
  input  logic                   e_is_div_i,
  input  logic                   d_uses_md_i,
  input  logic                   hz_stall_i,
  output logic                   md_busy_o,
  output logic                   md_done_o,
  output logic                   stall_o,
  output logic                   pc_we_o,
  output logic                   d_reg_we_o,
  output logic                   e_reg_clr_o,
  output logic                   m_reg_we_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  logic                   md_stall;
  logic                   stall;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_busy_counter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (e_start_i),
    .is_div_i (e_is_div_i),
    .busy_o   (md_busy_o),
    .done_o   (md_done_o)
  );

  // A HI/LO user in D waits both while the unit is busy and while a mult/div is issuing from E.
  assign md_stall = d_uses_md_i & (e_start_i | md_busy_o);
  assign stall    = hz_stall_i | md_stall;

  assign stall_o     = stall;
  assign pc_we_o     = ~stall;
  assign d_reg_we_o  = ~stall;
  assign e_reg_clr_o = stall;
  assign m_reg_we_o  = 1'b1;

  assign stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule
